load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit between the core's MEM stage and the word-addressed data memory. It accepts one RV32I load or store per request and performs sub-word extraction with sign or zero extension. Byte and halfword stores use a read-modify-write sequence, and misaligned or illegal accesses are rejected without touching memory. Memory-side ports connect directly to the data memory's `addr`, `din`, `mem_read`, `mem_write` and `dout`.

## Interface
- No parameters. Data width is fixed at 32 bits.

- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: the core presents a request.
- `req_ready` output 1: the unit accepts a request this cycle.
- `req_write` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV32I funct3.
  - Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Stores: SB=000, SH=001, SW=010.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data. The sub-word value is taken from the low bits.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: extended load data. It is 0 for stores and rejected accesses.
- `resp_misaligned` output 1: qualified by `resp_valid`. 1 means the access was rejected.
- `mem_addr` output 32: word-aligned address. Bits [1:0] are always 0.
- `mem_din` output 32: write data. It is 0 whenever `mem_write` = 0.
- `mem_read` output 1: memory read strobe.
- `mem_write` output 1: memory write strobe; memory commits on the clock edge.
- `mem_dout` input 32: memory read data, combinational from `mem_addr`.

## Operation
- **FSM states:** IDLE, LOAD, MERGE, WRITE, RESP.
- **IDLE**
  - `req_ready` = 1 in IDLE only.
  - On `req_valid && req_ready` the unit latches `req_write`, `req_funct3`, `req_addr` and `req_wdata`.
  - Next state is chosen from the latched request:
    - Rejected access → RESP.
    - Load → LOAD.
    - SW → WRITE.
    - SB or SH → MERGE.
- **Rejection rules:**
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] ≠ 00.
  - Load funct3 of 011, 110 or 111.
  - Store funct3 greater than 010.
- **LOAD**
  - `mem_read` = 1 and `mem_addr` = {addr[31:2], 2'b00}.
  - At the clock edge the unit registers the extracted and extended value, then goes to RESP.
- **MERGE**
  - `mem_read` = 1.
  - At the clock edge the unit registers `mem_dout` with the target lane replaced by store data, then goes to WRITE.
- **WRITE**
  - `mem_write` = 1.
  - `mem_din` = the merged word for SB/SH, or `req_wdata` for SW.
  - Then goes to RESP.
- **RESP**
  - `resp_valid` = 1 and `resp_misaligned` = the latched reject flag.
  - Then goes to IDLE.
- **Byte lanes (little-endian):**
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Halfword h = addr[1] occupies bits [16h+15:16h].
- **Extension:**
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
- **Strobes:** `mem_read` and `mem_write` are never asserted together. Neither is asserted in IDLE or RESP, or for a rejected access.

## Timing
- Acceptance edge = E0. Cycle n is the cycle after edge En−1.
- **Per-access latency:**
  - Load: LOAD in cycle 1, `resp_valid` in cycle 2.
  - SW: write commits at E1, `resp_valid` in cycle 2.
  - SB/SH: MERGE in cycle 1, WRITE in cycle 2 (commits at E2), `resp_valid` in cycle 3.
  - Rejected: `resp_valid` in cycle 1.
- **Ready after response:** `req_ready` returns to 1 in the cycle after `resp_valid`.
- **Throughput:** one request per 3 cycles for loads and SW, 4 for SB/SH, 2 for rejected accesses.
- **Request changes while busy:** `req_valid` and request fields are ignored outside IDLE. Changes mid-operation have no effect.
- **Held outputs:** `resp_rdata` and `resp_misaligned` hold their last values until the next RESP.
- **Reset**
  - Reset state: IDLE. All registers and all outputs are 0.
  - While `reset` is high, `req_ready`, `mem_read`, `mem_write` and `resp_valid` are forced to 0 combinationally. No write can land during reset.
  - `req_ready` = 1 in the first cycle after `reset` deasserts.
  - Reset in any state abandons the operation with no response.

## Test plan
- **SW then LW:** reset; SW addr 0x10, data 0xDEADBEEF → `mem_write` high for exactly cycle 1 with `mem_addr` = 0x10. Then LW 0x10 → `resp_rdata` = 0xDEADBEEF in cycle 2, `resp_misaligned` = 0.
- **Sub-word loads** on word 0xDEADBEEF at 0x10:
  - LB 0x13 → 0xFFFFFFDE.
  - LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD.
  - LHU 0x10 → 0x0000BEEF.
  - LB 0x10 → 0xFFFFFFEF.
- **Sub-word stores:**
  - SB 0x11, data 0x12345677 → written word 0xDEAD77EF; `resp_valid` in cycle 3.
  - Then SH 0x12, data 0xAAAA5555 → LW 0x10 returns 0x555577EF.
- **Rejections:** LW 0x12, SH 0x13 and load funct3 011 → each gives `resp_valid` and `resp_misaligned` = 1 in cycle 1, `resp_rdata` = 0. `mem_read` and `mem_write` are never asserted, and memory is unchanged.
- **Back-to-back requests:** `req_valid` held high with changing fields across consecutive loads → `req_ready` low while busy. Each request is accepted exactly once, and each response matches the fields latched at its own acceptance.
- **Reset mid-operation:** reset asserted during MERGE of an SB → no `mem_write` and no `resp_valid`. `req_ready` = 1 in the first cycle after reset deasserts.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RV32I load/store unit with sub-word extraction and read-modify-write stores
//   clk, reset                      : clock, synchronous active-high reset
//   req_valid/ready/write/funct3    : request handshake and decoded access type
//   req_addr, req_wdata             : byte address and store data (sub-word value in low bits)
//   resp_valid/rdata/misaligned     : one-cycle completion pulse, extended load data, reject flag
//   mem_addr/din/read/write, mem_dout : word-addressed data memory port
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);
    typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;
    state_t      state_q;
    logic        write_q, mis_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q, merged_q, rdata_q;
    logic        bad_d;
    logic [4:0]  sh;
    logic [31:0] lane, mask, load_d, merged_d;

    always_comb begin
        // illegal funct3 (loads 011/110/111, stores >010) or misaligned half/word
        bad_d = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && (req_write || req_funct3[1]))
             || (req_funct3[1:0] == 2'b01 && req_addr[0])
             || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        // halfwords are always 2-byte aligned here, so the byte shift also selects the halfword lane
        sh       = {addr_q[1:0], 3'b000};
        lane     = mem_dout >> sh;
        load_d   = funct3_q[1:0] == 2'b00 ? {{24{~funct3_q[2] & lane[7]}}, lane[7:0]} :
                   funct3_q[1:0] == 2'b01 ? {{16{~funct3_q[2] & lane[15]}}, lane[15:0]} : mem_dout;
        mask     = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        merged_d = (mem_dout & ~mask) | ((wdata_q << sh) & mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    write_q  <= req_write;
                    funct3_q <= req_funct3;
                    addr_q   <= req_addr;
                    wdata_q  <= req_wdata;
                    state_q  <= bad_d ? RESP : !req_write ? LOAD : req_funct3[1] ? WRITE : MERGE;
                    if (bad_d) begin
                        rdata_q <= '0;
                        mis_q   <= 1'b1;
                    end
                end
                LOAD: begin
                    rdata_q <= load_d;
                    mis_q   <= 1'b0;
                    state_q <= RESP;
                end
                MERGE: begin
                    merged_q <= merged_d;
                    state_q  <= WRITE;
                end
                WRITE: begin
                    rdata_q <= '0;
                    mis_q   <= 1'b0;
                    state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready       = !reset && state_q == IDLE;
    assign mem_read        = !reset && (state_q == LOAD || state_q == MERGE) && !write_q == (state_q == LOAD);
    assign mem_write       = !reset && state_q == WRITE;
    assign resp_valid      = !reset && state_q == RESP;
    assign mem_addr        = {addr_q[31:2], 2'b00};
    assign mem_din         = mem_write ? (funct3_q[1] ? wdata_q : merged_q) : '0;
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed-vector bench for load_store_unit with a behavioural word memory
module tb_load_store_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_misaligned, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;
    logic [31:0] mem [0:63] = '{default: 32'h0};
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read), .mem_write(mem_write),
        .mem_dout(mem_dout)
    );

    assign mem_dout = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_din;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        chk("ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~w; req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFF; req_wdata = ~d;
    endtask

    task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic mis,
                          output int nrd, output int nwr, output int wcyc,
                          output logic [31:0] waddr, output logic [31:0] wdin);
        start(w, f, a, d);
        lat = 0; nrd = 0; nwr = 0; wcyc = 0; rd = 'x; mis = 1'bx; waddr = 'x; wdin = 'x;
        for (int n = 1; n <= 6 && lat == 0; n++) begin
            @(negedge clk);
            chk("excl", {31'b0, mem_read & mem_write}, 32'd0);
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++; wcyc = n; waddr = mem_addr; wdin = mem_din;
            end
            if (resp_valid) begin
                lat = n; rd = resp_rdata; mis = resp_misaligned;
            end
        end
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        int lat, nrd, nwr, wcyc;
        logic [31:0] rd, waddr, wdin;
        logic mis;
        do_req(1'b1, 3'b010, a, d, lat, rd, mis, nrd, nwr, wcyc, waddr, wdin);
        chk("sw_lat", lat, 2);
        chk("sw_wcyc", wcyc, 1);
        chk("sw_nwr", nwr, 1);
        chk("sw_nrd", nrd, 0);
        chk("sw_addr", waddr, a);
        chk("sw_din", wdin, d);
        chk("sw_rdata", rd, 32'h0);
        chk("sw_mis", {31'b0, mis}, 32'd0);
    endtask

    task automatic ld(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] exp);
        int lat, nrd, nwr, wcyc;
        logic [31:0] rd, waddr, wdin;
        logic mis;
        do_req(1'b0, f, a, 32'h0, lat, rd, mis, nrd, nwr, wcyc, waddr, wdin);
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_mis"}, {31'b0, mis}, 32'd0);
        chk({tag, "_nrd"}, nrd, 1);
        chk({tag, "_nwr"}, nwr, 0);
    endtask

    task automatic sub_st(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp);
        int lat, nrd, nwr, wcyc;
        logic [31:0] rd, waddr, wdin;
        logic mis;
        do_req(1'b1, f, a, d, lat, rd, mis, nrd, nwr, wcyc, waddr, wdin);
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_wcyc"}, wcyc, 2);
        chk({tag, "_nrd"}, nrd, 1);
        chk({tag, "_nwr"}, nwr, 1);
        chk({tag, "_addr"}, waddr, {a[31:2], 2'b00});
        chk({tag, "_din"}, wdin, exp);
        chk({tag, "_mem"}, mem[a[7:2]], exp);
        chk({tag, "_rdata"}, rd, 32'h0);
    endtask

    task automatic rej(input string tag, input logic w, input logic [2:0] f, input logic [31:0] a);
        int lat, nrd, nwr, wcyc;
        logic [31:0] rd, waddr, wdin;
        logic mis;
        do_req(w, f, a, 32'hCAFE_F00D, lat, rd, mis, nrd, nwr, wcyc, waddr, wdin);
        chk({tag, "_lat"}, lat, 1);
        chk({tag, "_mis"}, {31'b0, mis}, 32'd1);
        chk({tag, "_rdata"}, rd, 32'h0);
        chk({tag, "_nrd"}, nrd, 0);
        chk({tag, "_nwr"}, nwr, 0);
        chk({tag, "_mem"}, mem[4], 32'h5555_77EF);
    endtask

    initial begin
        logic [31:0] ba [3] = '{32'h20, 32'h24, 32'h21};
        logic [2:0]  bf [3] = '{3'b010, 3'b010, 3'b100};
        logic [31:0] be [3] = '{32'h1111_1111, 32'h2222_2222, 32'h0000_0011};
        int k = 0, nr = 0, nrdy = 0;

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rv", {31'b0, resp_valid}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_rdata", resp_rdata, 32'h0);
        chk("post_rst_mis", {31'b0, resp_misaligned}, 32'd0);
        chk("post_rst_addr", mem_addr, 32'h0);
        chk("post_rst_din", mem_din, 32'h0);
        chk("post_rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);

        sw(32'h10, 32'hDEAD_BEEF);
        chk("sw_mem", mem[4], 32'hDEAD_BEEF);
        ld("lw", 3'b010, 32'h10, 32'hDEAD_BEEF);
        ld("lb13", 3'b000, 32'h13, 32'hFFFF_FFDE);
        ld("lbu13", 3'b100, 32'h13, 32'h0000_00DE);
        ld("lh12", 3'b001, 32'h12, 32'hFFFF_DEAD);
        ld("lhu10", 3'b101, 32'h10, 32'h0000_BEEF);
        ld("lb10", 3'b000, 32'h10, 32'hFFFF_FFEF);

        sub_st("sb11", 3'b000, 32'h11, 32'h1234_5677, 32'hDEAD_77EF);
        sub_st("sh12", 3'b001, 32'h12, 32'hAAAA_5555, 32'h5555_77EF);
        ld("lw_merged", 3'b010, 32'h10, 32'h5555_77EF);

        rej("rej_lw12", 1'b0, 3'b010, 32'h12);
        ld("lw_after_rej", 3'b010, 32'h10, 32'h5555_77EF);
        rej("rej_sh13", 1'b1, 3'b001, 32'h13);
        rej("rej_f011", 1'b0, 3'b011, 32'h10);
        rej("rej_sf100", 1'b1, 3'b100, 32'h10);

        sw(32'h20, 32'h1111_1111);
        sw(32'h24, 32'h2222_2222);
        sw(32'h28, 32'h3333_3333);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (nr < 3) chk($sformatf("b2b%0d", nr), resp_rdata, be[nr]);
                nr++;
            end
            if (c < 9 && req_ready) nrdy++;
            if (req_ready) begin
                if (k < 3) begin
                    req_valid = 1'b1; req_write = 1'b0; req_funct3 = bf[k]; req_addr = ba[k]; k++;
                end else req_valid = 1'b0;
            end else begin
                req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h28;
            end
        end
        req_valid = 1'b0;
        chk("b2b_count", nr, 3);
        chk("b2b_ready", nrdy, 3);

        start(1'b1, 3'b000, 32'h11, 32'h0000_00AB);
        @(negedge clk);
        chk("mid_merge_rd", {31'b0, mem_read}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_rd", {31'b0, mem_read}, 32'd0);
        @(negedge clk);
        chk("mid_wr", {31'b0, mem_write}, 32'd0);
        chk("mid_rv", {31'b0, resp_valid}, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_ready", {31'b0, req_ready}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("mid_norv", {31'b0, resp_valid | mem_write}, 32'd0);
        end
        chk("mid_mem", mem[4], 32'h5555_77EF);

        start(1'b1, 3'b000, 32'h11, 32'h0000_00AB);
        @(negedge clk);
        @(negedge clk);
        chk("wr_state_wr", {31'b0, mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        chk("wr_rst_wr", {31'b0, mem_write}, 32'd0);
        chk("wr_rst_din", mem_din, 32'h0);
        @(negedge clk);
        chk("wr_rst_rv", {31'b0, resp_valid}, 32'd0);
        reset = 1'b0;
        #1;
        chk("wr_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("wr_rst_mem", mem[4], 32'h5555_77EF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
